// File: rtl/exec_pkg.sv
// ============================================================================
// Module   : exec_pkg
// Brief    : Shared op codes, FSM states and helpers for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_pkg;

    localparam int OP_BITS = 5;
    typedef logic [OP_BITS-1:0] op_t;

    localparam op_t OP_ADD   = 5'd0;
    localparam op_t OP_SUB   = 5'd1;
    localparam op_t OP_AND   = 5'd2;
    localparam op_t OP_OR    = 5'd3;
    localparam op_t OP_XOR   = 5'd4;
    localparam op_t OP_SLL   = 5'd5;
    localparam op_t OP_SRL   = 5'd6;
    localparam op_t OP_SRA   = 5'd7;
    localparam op_t OP_SLT   = 5'd8;
    localparam op_t OP_SLTU  = 5'd9;
    localparam op_t OP_BEQ   = 5'd10;
    localparam op_t OP_BNE   = 5'd11;
    localparam op_t OP_BLT   = 5'd12;
    localparam op_t OP_BGE   = 5'd13;
    localparam op_t OP_BLTU  = 5'd14;
    localparam op_t OP_BGEU  = 5'd15;
    localparam op_t OP_MUL   = 5'd16;
    localparam op_t OP_MULH  = 5'd17;
    localparam op_t OP_MULHU = 5'd18;
    localparam op_t OP_RSVD  = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int PC_STEP = 4;

    function automatic logic is_branch_op(input op_t op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_mul_op(input op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_if.sv
// ============================================================================
// Module   : exec_if
// Brief    : Input/output handshake bundle of the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exec_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] data_a;
    logic [XLEN-1:0] data_b;
    logic [XLEN-1:0] imm;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] pc;
    logic            is_jump;
    logic            pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, data_a, data_b, imm, op, pc, is_jump, pred_taken, out_ready,
        input  in_ready, out_valid, result, redirect, redirect_pc
    );

    modport slave (
        input  in_valid, data_a, data_b, imm, op, pc, is_jump, pred_taken, out_ready,
        output in_ready, out_valid, result, redirect, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/exec_alu.sv
// ============================================================================
// Module   : exec_alu
// Brief    : Combinational single-cycle ALU and branch-condition evaluation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_alu
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    input  wire op_t             i_op,
    output logic      [XLEN-1:0] o_result,
    output logic                 o_cond
);

    localparam int c_SHAMT_W = $clog2(XLEN);

    logic [c_SHAMT_W-1:0] w_shamt;
    assign w_shamt = i_b[c_SHAMT_W-1:0];

    always_comb begin
        o_result = '0;
        o_cond   = 1'b0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLL:  o_result = i_a << w_shamt;
            OP_SRL:  o_result = i_a >> w_shamt;
            OP_SRA:  o_result = XLEN'($signed(i_a) >>> w_shamt);
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            OP_BEQ:  o_cond   = (i_a == i_b);
            OP_BNE:  o_cond   = (i_a != i_b);
            OP_BLT:  o_cond   = ($signed(i_a) < $signed(i_b));
            OP_BGE:  o_cond   = ($signed(i_a) >= $signed(i_b));
            OP_BLTU: o_cond   = (i_a < i_b);
            OP_BGEU: o_cond   = (i_a >= i_b);
            default: o_result = '0;
        endcase
        if (is_branch_op(i_op)) begin
            o_result = {{(XLEN-1){1'b0}}, o_cond};
        end
    end

endmodule

`default_nettype wire

// File: rtl/execute_unit.sv
// ============================================================================
// Module   : execute_unit
// Brief    : Execute stage: ALU, branch/jump resolution, optional iterative
//            multiplier (EXEC_MUL_EN), single registered output with handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic flush,
    exec_if.slave     bus
);

    op_t             w_op;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_cond;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_target;
    logic            w_is_branch;
    logic            w_taken;
    logic            w_sc_redirect;
    logic [XLEN-1:0] w_sc_redirect_pc;
    logic [XLEN-1:0] w_sc_result;
    logic            w_out_free;
    logic            w_accept;
    logic            w_load;
    logic [XLEN-1:0] w_load_result;
    logic            w_load_redirect;
    logic [XLEN-1:0] w_load_redirect_pc;

    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    // Codes that do not fit the package encoding decode as reserved.
    generate
        if (OP_W > OP_BITS) begin : g_op_wide
            assign w_op = (bus.op[OP_W-1:OP_BITS] == '0) ? bus.op[OP_BITS-1:0] : OP_RSVD;
        end else begin : g_op_narrow
            assign w_op = op_t'(bus.op);
        end
    endgenerate

    exec_alu #(.XLEN(XLEN)) u_alu (
        .i_a      (bus.data_a),
        .i_b      (bus.data_b),
        .i_op     (w_op),
        .o_result (w_alu_result),
        .o_cond   (w_alu_cond)
    );

    assign w_pc_next        = bus.pc + XLEN'(PC_STEP);
    assign w_pc_target      = bus.pc + bus.imm;
    assign w_is_branch      = is_branch_op(w_op);
    assign w_taken          = bus.is_jump | (w_is_branch & w_alu_cond);
    assign w_sc_redirect    = (bus.is_jump | w_is_branch) & (w_taken != bus.pred_taken);
    assign w_sc_redirect_pc = w_sc_redirect ? (w_taken ? w_pc_target : w_pc_next) : '0;
    assign w_sc_result      = bus.is_jump ? w_pc_next : w_alu_result;
    assign w_out_free       = !r_out_valid || bus.out_ready;

`ifdef EXEC_MUL_EN
    localparam int c_CNT_W = $clog2(XLEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*XLEN-1:0]    r_mcand;
    logic [XLEN-1:0]      r_mplier;
    logic [2*XLEN-1:0]    r_prod;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg;
    logic                 r_mul_lo;

    logic                 w_start_mul;
    logic                 w_mul_done;
    logic                 w_mul_load;
    logic                 w_is_mulh;
    logic [XLEN-1:0]      w_a_mag;
    logic [XLEN-1:0]      w_b_mag;
    logic [2*XLEN-1:0]    w_addend;
    logic [2*XLEN-1:0]    w_prod_full;
    logic [2*XLEN-1:0]    w_prod_signed;

    assign bus.in_ready = (r_state == IDLE) && w_out_free;
    assign w_accept     = bus.in_valid && bus.in_ready && !flush;
    assign w_start_mul  = w_accept && is_mul_op(w_op) && !bus.is_jump;
    assign w_mul_done   = (r_state == MUL) && (r_cnt == c_CNT_W'(XLEN-1));
    assign w_mul_load   = !flush && w_out_free && (w_mul_done || (r_state == HOLD));

    // MULH multiplies magnitudes and re-applies the sign at the end.
    assign w_is_mulh     = (w_op == OP_MULH);
    assign w_a_mag       = (w_is_mulh && bus.data_a[XLEN-1]) ? -bus.data_a : bus.data_a;
    assign w_b_mag       = (w_is_mulh && bus.data_b[XLEN-1]) ? -bus.data_b : bus.data_b;
    assign w_addend      = ((r_state == MUL) && r_mplier[0]) ? r_mcand : '0;
    assign w_prod_full   = r_prod + w_addend;
    assign w_prod_signed = r_neg ? -w_prod_full : w_prod_full;

    assign w_load             = (w_accept && !w_start_mul) || w_mul_load;
    assign w_load_result      = w_mul_load ? (r_mul_lo ? w_prod_signed[XLEN-1:0]
                                                       : w_prod_signed[2*XLEN-1:XLEN])
                                           : w_sc_result;
    assign w_load_redirect    = w_mul_load ? 1'b0 : w_sc_redirect;
    assign w_load_redirect_pc = w_mul_load ? '0 : w_sc_redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_mul) w_state_nxt = MUL;
            MUL:     if (w_mul_done)  w_state_nxt = w_out_free ? IDLE : HOLD;
            HOLD:    if (w_out_free)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_mul_lo <= 1'b0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_start_mul) begin
            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= w_is_mulh && (bus.data_a[XLEN-1] ^ bus.data_b[XLEN-1]);
            r_mul_lo <= (w_op == OP_MUL);
        end else if (r_state == MUL) begin
            r_prod   <= w_prod_full;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (!w_mul_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign bus.in_ready       = w_out_free;
    assign w_accept           = bus.in_valid && bus.in_ready && !flush;
    assign w_load             = w_accept;
    assign w_load_result      = w_sc_result;
    assign w_load_redirect    = w_sc_redirect;
    assign w_load_redirect_pc = w_sc_redirect_pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_result      <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_redirect  <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_result      <= w_load_result;
            r_redirect    <= w_load_redirect;
            r_redirect_pc <= w_load_redirect_pc;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_redirect  <= 1'b0;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_execute_unit.sv
// ============================================================================
// Module   : tb_execute_unit
// Brief    : Directed self-checking bench for execute_unit (either build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_unit;
    import exec_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;

    exec_if #(.XLEN(XLEN), .OP_W(5)) bus ();

    execute_unit #(.XLEN(XLEN), .OP_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic jmp, input logic pred);
        bus.in_valid   = 1'b1;
        bus.op         = op;
        bus.data_a     = a;
        bus.data_b     = b;
        bus.pc         = pc;
        bus.imm        = imm;
        bus.is_jump    = jmp;
        bus.pred_taken = pred;
    endtask

    task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic jmp, input logic pred);
        drive(op, a, b, pc, imm, jmp, pred);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res,
                             input logic rd, input logic [31:0] rpc);
        check({tag, ".valid"},    32'(bus.out_valid), 32'd1);
        check({tag, ".result"},   bus.result, res);
        check({tag, ".redirect"}, 32'(bus.redirect), 32'(rd));
        check({tag, ".rpc"},      bus.redirect_pc, rpc);
    endtask

`ifdef EXEC_MUL_EN
    task automatic run_mul(input string tag, input op_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res);
        run_op(op, a, b, 32'h0, 32'h0, 1'b0, 1'b0);
        check({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
        repeat (XLEN - 1) step();
        check({tag, ".early"}, 32'(bus.out_valid), 32'd0);
        step();
        check_out(tag, res, 1'b0, 32'h0);
    endtask
`endif

    initial begin
        logic seen;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.op         = OP_ADD;
        bus.data_a     = '0;
        bus.data_b     = '0;
        bus.pc         = '0;
        bus.imm        = '0;
        bus.is_jump    = 1'b0;
        bus.pred_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result",    bus.result, 32'd0);
        check("rst.redirect",  32'(bus.redirect), 32'd0);
        check("rst.rpc",       bus.redirect_pc, 32'd0);
        check("rst.in_ready",  32'(bus.in_ready), 32'd1);

        // ALU patterns
        run_op(OP_ADD,  32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("add_wrap", 32'd1, 1'b0, 32'h0);
        run_op(OP_ADD,  32'd5, 32'd7, 32'h80, 32'h10, 1'b0, 1'b1);
        check_out("add_pred", 32'd12, 1'b0, 32'h0);
        run_op(OP_SUB,  32'd3, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("sub", 32'hFFFFFFFE, 1'b0, 32'h0);
        run_op(OP_SRA,  32'h80000000, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("sra", 32'hF8000000, 1'b0, 32'h0);
        run_op(OP_SLL,  32'd1, 32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("sll_mask", 32'h10, 1'b0, 32'h0);
        run_op(OP_SLT,  32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("slt", 32'd0, 1'b0, 32'h0);
        run_op(OP_SLTU, 32'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("sltu", 32'd1, 1'b0, 32'h0);

        // Branches and jumps
        run_op(OP_BEQ,  32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b0);
        check_out("beq_mispred", 32'd1, 1'b1, 32'h120);
        run_op(OP_BNE,  32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b1);
        check_out("bne_mispred", 32'd0, 1'b1, 32'h104);
        run_op(OP_BNE,  32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b0);
        check_out("bne_ok", 32'd0, 1'b0, 32'h0);
        run_op(OP_BLT,  32'hFFFFFFFF, 32'd1, 32'h300, 32'hFFFFFFF0, 1'b0, 1'b0);
        check_out("blt_back", 32'd1, 1'b1, 32'h2F0);
        run_op(OP_BGEU, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h8, 1'b0, 1'b1);
        check_out("bgeu_ok", 32'd1, 1'b0, 32'h0);
        run_op(OP_ADD,  32'd9, 32'd9, 32'h200, 32'h40, 1'b1, 1'b1);
        check_out("jump_ok", 32'h204, 1'b0, 32'h0);
        run_op(OP_ADD,  32'd9, 32'd9, 32'h200, 32'h40, 1'b1, 1'b0);
        check_out("jump_mispred", 32'h204, 1'b1, 32'h240);
        run_op(OP_SUB,  32'd9, 32'd9, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b0);
        check_out("jump_wrap", 32'h0, 1'b1, 32'h4);
        run_op(5'd20,   32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b1);
        check_out("reserved", 32'h0, 1'b0, 32'h0);
        step();
        check("drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        drive(OP_ADD, 32'd10, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        check_out("bp_first", 32'd13, 1'b0, 32'h0);
        drive(OP_SUB, 32'd10, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold.result", bus.result, 32'd13);
            check("bp_hold.in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check_out("bp_sub", 32'd7, 1'b0, 32'h0);
        step();
        check("bp_drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Flush drops a same-cycle input and kills a pending output
        drive(OP_ADD, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_in.out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in.in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        run_op(OP_BEQ, 32'd1, 32'd1, 32'h100, 32'h20, 1'b0, 1'b0);
        check("flush_pend.pre", 32'(bus.redirect), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_pend.out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_pend.redirect", 32'(bus.redirect), 32'd0);

`ifdef EXEC_MUL_EN
        run_mul("mulh_neg",  OP_MULH,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
        run_mul("mulh_min",  OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000);
        run_mul("mulhu_max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_mul("mul_lo",    OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        step();

        run_op(OP_MULH, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("mul_flush.in_ready", 32'(bus.in_ready), 32'd1);
        check("mul_flush.out_valid", 32'(bus.out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        check("mul_flush.no_output", 32'(seen), 32'd0);
`else
        run_op(OP_MULH, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 1'b0, 1'b1);
        check_out("mulh_reserved", 32'h0, 1'b0, 32'h0);
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out("mulhu_reserved", 32'h0, 1'b0, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
